// File: rtl/gshare_bpred.sv
// Gshare/bimodal direction predictor: folded-PC (optionally XOR GHR) indexed saturating
// counters, registered prediction, Execute-stage training and GHR repair on mispredict.
//
// state  | meaning
// S_INIT | walking the table writing INIT_VAL, one entry per cycle; inputs ignored
// S_RUN  | predicting and training; left only by rst
module gshare_bpred #(
    parameter int IDX_BITS  = 8,
    parameter int CTR_BITS  = 2,
    parameter int HIST_BITS = 8,
    parameter int USE_GHR   = 1,
    parameter logic [CTR_BITS-1:0] INIT_VAL = {1'b1, {(CTR_BITS-1){1'b0}}}
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 fetch_vld,
    input  logic [31:0]          pc_cur,
    output logic                 predict_vld,
    output logic                 predict_take,
    output logic [IDX_BITS-1:0]  predict_idx,
    output logic [HIST_BITS-1:0] predict_ghr,
    input  logic                 upd_vld,
    input  logic [IDX_BITS-1:0]  upd_idx,
    input  logic                 upd_taken,
    input  logic                 upd_mispredict,
    input  logic [HIST_BITS-1:0] upd_ghr,
    output logic                 ready
);
    localparam int DEPTH = 2**IDX_BITS;
    localparam int NSL   = (30 + IDX_BITS - 1) / IDX_BITS;
    localparam logic [CTR_BITS-1:0] CTR_MAX = '1;

    typedef enum logic {S_INIT, S_RUN} state_e;

    state_e                state_q, state_d;
    logic [IDX_BITS-1:0]   init_ptr_q, init_ptr_d;
    logic [HIST_BITS-1:0]  ghr_q, ghr_d;
    logic                  pvld_q, pvld_d;
    logic                  ptake_q, ptake_d;
    logic [IDX_BITS-1:0]   pidx_q, pidx_d;
    logic [HIST_BITS-1:0]  pghr_q, pghr_d;
    logic [CTR_BITS-1:0]   table_q [DEPTH];

    logic [NSL*IDX_BITS-1:0] pc_pad;
    logic [IDX_BITS-1:0]     fold, idx, ghr_ext;
    logic [CTR_BITS-1:0]     rd_ctr, upd_cur, upd_ctr;
    logic                    pred_dir, init_we, upd_we;
    logic [HIST_BITS:0]      shift_w, repair_w;
    logic                    unused_pc;

    assign unused_pc = ^pc_cur[1:0];
    assign pc_pad    = (NSL*IDX_BITS)'(pc_cur[31:2]);
    assign ghr_ext   = IDX_BITS'(ghr_q);

    always_comb begin
        fold = '0;
        for (int s = 0; s < NSL; s++) begin
            fold = fold ^ pc_pad[s*IDX_BITS +: IDX_BITS];
        end
    end

    assign idx      = fold ^ ((USE_GHR != 0) ? ghr_ext : '0);
    assign rd_ctr   = table_q[idx];
    assign pred_dir = rd_ctr[CTR_BITS-1];
    assign shift_w  = {ghr_q, pred_dir};
    assign repair_w = {upd_ghr, upd_taken};

    // Saturating update; the table write is registered, so same-cycle reads see the old value.
    assign upd_cur = table_q[upd_idx];
    always_comb begin
        upd_ctr = upd_cur;
        if (upd_taken) begin
            if (upd_cur != CTR_MAX) upd_ctr = upd_cur + 1'b1;
        end else begin
            if (upd_cur != '0) upd_ctr = upd_cur - 1'b1;
        end
    end

    always_comb begin
        state_d    = state_q;
        init_ptr_d = init_ptr_q;
        ghr_d      = ghr_q;
        pvld_d     = 1'b0;
        ptake_d    = ptake_q;
        pidx_d     = pidx_q;
        pghr_d     = pghr_q;
        init_we    = 1'b0;
        upd_we     = 1'b0;
        case (state_q)
            S_INIT: begin
                init_we    = 1'b1;
                init_ptr_d = init_ptr_q + 1'b1;
                if (init_ptr_q == '1) state_d = S_RUN;
            end
            S_RUN: begin
                upd_we = upd_vld;
                if (fetch_vld) begin
                    pvld_d  = 1'b1;
                    ptake_d = pred_dir;
                    pidx_d  = idx;
                    pghr_d  = ghr_q;
                    ghr_d   = shift_w[HIST_BITS-1:0];
                end
                if (upd_vld && upd_mispredict) ghr_d = repair_w[HIST_BITS-1:0];
            end
            default: state_d = S_INIT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_INIT;
            init_ptr_q <= '0;
            ghr_q      <= '0;
            pvld_q     <= 1'b0;
            ptake_q    <= 1'b0;
            pidx_q     <= '0;
            pghr_q     <= '0;
        end else begin
            state_q    <= state_d;
            init_ptr_q <= init_ptr_d;
            ghr_q      <= ghr_d;
            pvld_q     <= pvld_d;
            ptake_q    <= ptake_d;
            pidx_q     <= pidx_d;
            pghr_q     <= pghr_d;
        end
    end

    // Contents are meaningless until the walk completes, so the array carries no reset.
    always_ff @(posedge clk) begin
        if (init_we) begin
            table_q[init_ptr_q] <= INIT_VAL;
        end else if (upd_we) begin
            table_q[upd_idx] <= upd_ctr;
        end
    end

    assign predict_vld  = pvld_q;
    assign predict_take = ptake_q;
    assign predict_idx  = pidx_q;
    assign predict_ghr  = pghr_q;
    assign ready        = (state_q == S_RUN);
endmodule

// File: tb/tb_gshare_bpred.sv
// Scoreboard bench for gshare_bpred: a gshare instance (g_) and a bimodal instance (b_)
// driven with directed vectors; a negedge monitor pops expected predictions.
module tb_gshare_bpred;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       g_fetch_vld, g_upd_vld, g_upd_taken, g_upd_misp;
    logic [31:0] g_pc;
    logic [7:0] g_upd_idx, g_upd_ghr;
    logic       g_pvld, g_ptake, g_ready;
    logic [7:0] g_pidx, g_pghr;

    logic       b_fetch_vld, b_upd_vld, b_upd_taken, b_upd_misp;
    logic [31:0] b_pc;
    logic [7:0] b_upd_idx, b_upd_ghr;
    logic       b_pvld, b_ptake, b_ready;
    logic [7:0] b_pidx, b_pghr;

    gshare_bpred #(.IDX_BITS(8), .CTR_BITS(2), .HIST_BITS(8), .USE_GHR(1)) dut_g (
        .clk(clk), .rst(rst), .fetch_vld(g_fetch_vld), .pc_cur(g_pc),
        .predict_vld(g_pvld), .predict_take(g_ptake), .predict_idx(g_pidx), .predict_ghr(g_pghr),
        .upd_vld(g_upd_vld), .upd_idx(g_upd_idx), .upd_taken(g_upd_taken),
        .upd_mispredict(g_upd_misp), .upd_ghr(g_upd_ghr), .ready(g_ready));

    gshare_bpred #(.IDX_BITS(8), .CTR_BITS(2), .HIST_BITS(8), .USE_GHR(0)) dut_b (
        .clk(clk), .rst(rst), .fetch_vld(b_fetch_vld), .pc_cur(b_pc),
        .predict_vld(b_pvld), .predict_take(b_ptake), .predict_idx(b_pidx), .predict_ghr(b_pghr),
        .upd_vld(b_upd_vld), .upd_idx(b_upd_idx), .upd_taken(b_upd_taken),
        .upd_mispredict(b_upd_misp), .upd_ghr(b_upd_ghr), .ready(b_ready));

    typedef struct {
        logic       take;
        logic [7:0] idx;
        logic [7:0] ghr;
        bit         chk_ghr;
    } exp_t;

    exp_t q_g[$];
    exp_t q_b[$];
    int checks   = 0;
    int failures = 0;

    task automatic check(string name, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (g_pvld) begin
            if (q_g.size() == 0) begin
                check("g_unexpected_predict_vld", 32'd1, 32'd0);
            end else begin
                e = q_g.pop_front();
                check("g_take", {31'd0, g_ptake}, {31'd0, e.take});
                check("g_idx", {24'd0, g_pidx}, {24'd0, e.idx});
                if (e.chk_ghr) check("g_ghr", {24'd0, g_pghr}, {24'd0, e.ghr});
            end
        end
        if (b_pvld) begin
            if (q_b.size() == 0) begin
                check("b_unexpected_predict_vld", 32'd1, 32'd0);
            end else begin
                e = q_b.pop_front();
                check("b_take", {31'd0, b_ptake}, {31'd0, e.take});
                check("b_idx", {24'd0, b_pidx}, {24'd0, e.idx});
                if (e.chk_ghr) check("b_ghr", {24'd0, b_pghr}, {24'd0, e.ghr});
            end
        end
    end

    task automatic clear_inputs();
        g_fetch_vld = 0; g_pc = 0; g_upd_vld = 0; g_upd_idx = 0; g_upd_taken = 0;
        g_upd_misp = 0; g_upd_ghr = 0;
        b_fetch_vld = 0; b_pc = 0; b_upd_vld = 0; b_upd_idx = 0; b_upd_taken = 0;
        b_upd_misp = 0; b_upd_ghr = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        clear_inputs();
    endtask

    task automatic fetch(int d, logic [31:0] pc, logic take, logic [7:0] idx,
                         logic [7:0] ghr, bit chkg);
        exp_t e;
        e.take = take; e.idx = idx; e.ghr = ghr; e.chk_ghr = chkg;
        if (d == 0) begin
            g_fetch_vld = 1; g_pc = pc; q_g.push_back(e);
        end else begin
            b_fetch_vld = 1; b_pc = pc; q_b.push_back(e);
        end
    endtask

    task automatic upd(int d, logic vld, logic [7:0] idx, logic taken, logic misp, logic [7:0] ghr);
        if (d == 0) begin
            g_upd_vld = vld; g_upd_idx = idx; g_upd_taken = taken; g_upd_misp = misp; g_upd_ghr = ghr;
        end else begin
            b_upd_vld = vld; b_upd_idx = idx; b_upd_taken = taken; b_upd_misp = misp; b_upd_ghr = ghr;
        end
    endtask

    // Walk of 256 cycles with fetch/update noise that must be ignored.
    task automatic walk_check(string tag);
        for (int k = 1; k <= 256; k++) begin
            g_fetch_vld = 1; g_pc = k * 4;
            b_fetch_vld = 1; b_pc = k * 8;
            upd(0, 1'b1, 8'hFF, 1'b1, 1'b1, 8'hFF);
            upd(1, 1'b1, 8'h22, 1'b0, 1'b1, 8'hAA);
            tick();
            check($sformatf("%s_g_ready_c%0d", tag, k), {31'd0, g_ready}, (k == 256) ? 32'd1 : 32'd0);
            check($sformatf("%s_b_ready_c%0d", tag, k), {31'd0, b_ready}, (k == 256) ? 32'd1 : 32'd0);
        end
        check({tag, "_g_pvld_after_walk"}, {31'd0, g_pvld}, 32'd0);
        check({tag, "_b_pvld_after_walk"}, {31'd0, b_pvld}, 32'd0);
    endtask

    task automatic ub(logic [7:0] idx, logic taken);
        upd(1, 1'b1, idx, taken, 1'b0, 8'h00);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_inputs();
        rst = 1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_g_pvld", {31'd0, g_pvld}, 32'd0);
        check("rst_g_pidx", {24'd0, g_pidx}, 32'd0);
        rst = 0;
        check("g_ready_c0", {31'd0, g_ready}, 32'd0);
        check("b_ready_c0", {31'd0, b_ready}, 32'd0);
        walk_check("walk1");

        // gshare: index = fold ^ GHR, GHR shifts in predicted taken
        fetch(0, 32'h0000_0404, 1'b1, 8'h00, 8'h00, 1); tick();
        fetch(0, 32'h0000_0404, 1'b1, 8'h01, 8'h01, 1); tick();
        fetch(0, 32'h0000_0404, 1'b1, 8'h03, 8'h03, 1); tick();
        // repair beats the concurrent fetch shift: GHR 0x07 -> 0x1E
        fetch(0, 32'h0000_0404, 1'b1, 8'h07, 8'h07, 1);
        upd(0, 1'b1, 8'h80, 1'b0, 1'b1, 8'h0F); tick();
        fetch(0, 32'h0000_0404, 1'b1, 8'h1E, 8'h1E, 1); tick();
        // mispredict without upd_vld is ignored
        fetch(0, 32'h0000_0404, 1'b1, 8'h3D, 8'h3D, 1);
        upd(0, 1'b0, 8'h00, 1'b0, 1'b1, 8'hAA); tick();
        fetch(0, 32'h0000_0404, 1'b1, 8'h7B, 8'h7B, 1); tick();
        upd(0, 1'b1, 8'h40, 1'b0, 1'b0, 8'h00); tick();
        check("g_hold_pvld", {31'd0, g_pvld}, 32'd0);
        check("g_hold_idx", {24'd0, g_pidx}, 32'h7B);
        check("g_hold_ghr", {24'd0, g_pghr}, 32'h7B);
        upd(0, 1'b1, 8'h40, 1'b0, 1'b0, 8'h00); tick();
        fetch(0, 32'h0000_02DC, 1'b0, 8'h40, 8'hF7, 1); tick();
        fetch(0, 32'h0000_01B8, 1'b0, 8'h80, 8'hEE, 1); tick();

        // bimodal: fold of full PC, saturation, collision
        fetch(1, 32'h1234_5678, 1'b1, 8'h02, 8'h00, 0); tick();
        fetch(1, 32'hFFFF_FFFC, 1'b1, 8'hC0, 8'h00, 0); tick();
        repeat (4) ub(8'h05, 1'b1);
        fetch(1, 32'h0000_0014, 1'b1, 8'h05, 8'h00, 0); tick();
        ub(8'h05, 1'b0);
        fetch(1, 32'h0000_0014, 1'b1, 8'h05, 8'h00, 0); tick();
        ub(8'h05, 1'b0);
        fetch(1, 32'h0000_0014, 1'b0, 8'h05, 8'h00, 0); tick();
        repeat (3) ub(8'h05, 1'b0);
        ub(8'h05, 1'b1);
        fetch(1, 32'h0000_0014, 1'b0, 8'h05, 8'h00, 0); tick();
        ub(8'h05, 1'b1);
        fetch(1, 32'h0000_0014, 1'b1, 8'h05, 8'h00, 0); tick();
        ub(8'h22, 1'b0);
        fetch(1, 32'h0000_0088, 1'b0, 8'h22, 8'h00, 0);
        upd(1, 1'b1, 8'h22, 1'b1, 1'b0, 8'h00); tick();
        fetch(1, 32'h0000_0088, 1'b1, 8'h22, 8'h00, 0); tick();
        repeat (2) ub(8'h22, 1'b0);
        fetch(1, 32'h0000_0088, 1'b0, 8'h22, 8'h00, 0); tick();
        tick();

        // reset, then a second reset mid-walk at init_ptr=100
        rst = 1; tick(); tick(); rst = 0;
        repeat (100) tick();
        check("mid_g_ready_c100", {31'd0, g_ready}, 32'd0);
        rst = 1;
        #1;
        check("mid_rst_g_ready", {31'd0, g_ready}, 32'd0);
        check("mid_rst_b_ready", {31'd0, b_ready}, 32'd0);
        tick();
        rst = 0;
        walk_check("walk2");

        fetch(0, 32'h0000_0100, 1'b1, 8'h40, 8'h00, 1);
        fetch(1, 32'h0000_0088, 1'b1, 8'h22, 8'h00, 0); tick();
        fetch(0, 32'h0000_0204, 1'b1, 8'h80, 8'h01, 1); tick();
        tick(); tick();

        check("g_queue_drained", q_g.size(), 32'd0);
        check("b_queue_drained", q_b.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
